// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: the instruction-in side and the immediate-out side.
// slave is the block itself; master is the upstream/downstream environment.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic             err;
    logic [CNT_W-1:0] issued_cnt;

    modport slave (
        input  in_valid, inst, op, out_ready,
        output in_ready, out_valid, imm, err, issued_cnt
    );

    modport master (
        output in_valid, inst, op, out_ready,
        input  in_ready, out_valid, imm, err, issued_cnt
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry output FIFO and an issued-immediate counter.
// Optional macro IMM_GEN_ZIMM_EN enables op=5 (CSR zimm); otherwise op=5 is reserved.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    imm_gen_pipe_if.slave bus
);

    generate
        if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [31:0]     imm32;
    logic            bad_op;
    logic [XLEN-1:0] imm_ext;
    logic            unused_opcode;

    assign unused_opcode = ^bus.inst[6:0];

    // Every format places its sign at bit 31 of imm32, so one sign-extension covers all.
    always_comb begin
        imm32  = '0;
        bad_op = 1'b0;
        case (bus.op)
            3'd0: imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
            3'd1: imm32 = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
            3'd2: imm32 = {{20{bus.inst[31]}}, bus.inst[7], bus.inst[30:25],
                           bus.inst[11:8], 1'b0};
            3'd3: imm32 = {bus.inst[31:12], 12'b0};
            3'd4: imm32 = {{12{bus.inst[31]}}, bus.inst[19:12], bus.inst[20],
                           bus.inst[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
            3'd5: imm32 = {27'b0, bus.inst[19:15]};
`endif
            default: begin
                imm32  = '0;
                bad_op = 1'b1;
            end
        endcase
    end

    assign imm_ext = XLEN'(signed'(imm32));

    logic [XLEN-1:0]  mem_imm_q [2];
    logic             mem_err_q [2];
    logic             wptr_q;
    logic             rptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;

    // count guard keeps a stray push while full from corrupting the head entry.
    assign push = bus.in_valid && in_ready_q && (count_q != 2'd2);
    assign pop  = bus.out_ready && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_imm_q[i] <= '0;
                mem_err_q[i] <= 1'b0;
            end
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (push) begin
                mem_imm_q[wptr_q] <= imm_ext;
                mem_err_q[wptr_q] <= bad_op;
                wptr_q            <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            count_q    <= count_d;
            in_ready_q <= (count_d != 2'd2);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (count_q != 2'd0);
    assign bus.imm        = bus.out_valid ? mem_imm_q[rptr_q] : '0;
    assign bus.err        = bus.out_valid ? mem_err_q[rptr_q] : 1'b0;
    assign bus.issued_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 instance and one XLEN=64 instance.
// Expected zimm behaviour follows whether IMM_GEN_ZIMM_EN is defined for the build.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .CNT_W(16)) a ();
    imm_gen_pipe_if #(.XLEN(64), .CNT_W(16)) b ();

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] z_imm;
    logic        z_err;

    initial begin
`ifdef IMM_GEN_ZIMM_EN
        z_imm = 32'h0000001F;
        z_err = 1'b0;
`else
        z_imm = 32'h0;
        z_err = 1'b1;
`endif
        rst         = 1'b1;
        a.in_valid  = 1'b0;
        a.inst      = '0;
        a.op        = '0;
        a.out_ready = 1'b1;
        b.in_valid  = 1'b0;
        b.inst      = '0;
        b.op        = '0;
        b.out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_in_ready", 64'(a.in_ready), 64'd0);
        chk("rst_out_valid", 64'(a.out_valid), 64'd0);
        chk("rst_imm", 64'(a.imm), 64'd0);
        chk("rst_err", 64'(a.err), 64'd0);
        chk("rst_cnt", 64'(a.issued_cnt), 64'd0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 64'(a.in_ready), 64'd1);

        // I-type, single-cycle latency
        a.in_valid = 1'b1; a.inst = 32'hFFF00093; a.op = 3'd0;
        step();
        chk("i_valid", 64'(a.out_valid), 64'd1);
        chk("i_imm", 64'(a.imm), 64'h00000000FFFFFFFF);
        chk("i_err", 64'(a.err), 64'd0);

        // Back-to-back S, B, J
        a.inst = 32'hFE20AE23; a.op = 3'd1;
        step();
        chk("s_imm", 64'(a.imm), 64'h00000000FFFFFFFC);
        chk("s_cnt", 64'(a.issued_cnt), 64'd1);
        a.inst = 32'hFE000CE3; a.op = 3'd2;
        step();
        chk("b_imm", 64'(a.imm), 64'h00000000FFFFFFF8);
        chk("b_valid", 64'(a.out_valid), 64'd1);
        a.inst = 32'hFFDFF06F; a.op = 3'd4;
        step();
        chk("j_imm", 64'(a.imm), 64'h00000000FFFFFFFC);
        a.in_valid = 1'b0;
        step();
        chk("sbj_drained", 64'(a.out_valid), 64'd0);
        chk("sbj_cnt", 64'(a.issued_cnt), 64'd4);

        // XLEN=64 U-type
        b.in_valid = 1'b1; b.inst = 32'h800000B7; b.op = 3'd3;
        step();
        chk("u64_neg", b.imm, 64'hFFFFFFFF80000000);
        b.inst = 32'h12345037;
        step();
        chk("u64_pos", b.imm, 64'h0000000012345000);
        b.in_valid = 1'b0;
        step();
        chk("u64_cnt", 64'(b.issued_cnt), 64'd2);

        // Backpressure: three I-type pushes with out_ready low
        a.out_ready = 1'b0;
        a.in_valid = 1'b1; a.inst = 32'h00100093; a.op = 3'd0;
        step();
        chk("bp1_imm", 64'(a.imm), 64'd1);
        chk("bp1_in_ready", 64'(a.in_ready), 64'd1);
        a.inst = 32'h00200093;
        step();
        chk("bp2_in_ready", 64'(a.in_ready), 64'd0);
        chk("bp2_imm_stable", 64'(a.imm), 64'd1);
        a.inst = 32'h00300093;
        step();
        chk("bp3_in_ready", 64'(a.in_ready), 64'd0);
        chk("bp3_imm_stable", 64'(a.imm), 64'd1);
        a.out_ready = 1'b1;
        step();
        chk("drain_2", 64'(a.imm), 64'd2);
        chk("drain_in_ready", 64'(a.in_ready), 64'd1);
        step();
        chk("drain_3", 64'(a.imm), 64'd3);
        a.in_valid = 1'b0;
        step();
        chk("drain_empty", 64'(a.out_valid), 64'd0);
        chk("drain_cnt", 64'(a.issued_cnt), 64'd7);

        // Reserved op and Z op
        a.out_ready = 1'b0;
        a.in_valid = 1'b1; a.inst = 32'hFFF00093; a.op = 3'd7;
        step();
        chk("op7_imm", 64'(a.imm), 64'd0);
        chk("op7_err", 64'(a.err), 64'd1);
        a.out_ready = 1'b1;
        a.inst = 32'h000F8073; a.op = 3'd5;
        step();
        chk("z_imm", 64'(a.imm), 64'(z_imm));
        chk("z_err", 64'(a.err), 64'(z_err));
        a.in_valid = 1'b0;
        step();
        chk("z_empty_err", 64'(a.err), 64'd0);
        chk("z_cnt", 64'(a.issued_cnt), 64'd9);

        // Reset with a full buffer
        a.out_ready = 1'b0;
        a.in_valid = 1'b1; a.inst = 32'h00500093; a.op = 3'd0;
        step();
        a.inst = 32'h00600093;
        step();
        chk("full_in_ready", 64'(a.in_ready), 64'd0);
        a.in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 64'(a.out_valid), 64'd0);
        chk("mid_rst_cnt", 64'(a.issued_cnt), 64'd0);
        chk("mid_rst_in_ready", 64'(a.in_ready), 64'd0);
        rst = 1'b0;
        a.out_ready = 1'b1;
        step();
        chk("after_rst_in_ready", 64'(a.in_ready), 64'd1);
        chk("after_rst_valid", 64'(a.out_valid), 64'd0);
        step();
        chk("no_stale", 64'(a.out_valid), 64'd0);
        a.in_valid = 1'b1; a.inst = 32'h00700093;
        step();
        chk("fresh_imm", 64'(a.imm), 64'd7);
        a.in_valid = 1'b0;
        step();
        chk("fresh_cnt", 64'(a.issued_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle sign-extension unit.
- Takes a full 32-bit instruction word plus a format select, and produces the immediate sign-extended (or zero-extended) to XLEN.
- Has a 2-entry output buffer with valid/ready handshakes on both sides.
- Sits between fetch/decode and the register-read stage of the pipelined core.
- Also flags unsupported formats and counts issued immediates.

Parameters:
- XLEN, 32, output width; legal values 32 or 64. Any other value is a synthesis-time error.
- CNT_W, 16, width of the issued-immediate counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept; registered, no combinational path from out_ready.
- inst  in  32  full instruction word; immediate fields taken from inst[31:7].
- op  in  3  format select: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm), 6/7 reserved.
- out_valid  out  1  head of buffer holds a result.
- out_ready  in  1  downstream accepts.
- imm  out  XLEN  immediate at buffer head.
- err  out  1  head entry had an unsupported op.
- issued_cnt  out  CNT_W  number of completed output handshakes.

Behaviour:
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- Latency: an entry accepted in cycle N is visible on imm/out_valid in cycle N+1.
- Throughput: 1 per cycle with out_ready held high.
- Buffer: 2-entry FIFO with count in 0..2.
  - in_ready = (count != 2), registered from next-state count.
  - out_valid = (count != 0).
  - Order is strictly FIFO.
- Simultaneous push and pop:
  - count 1: count stays 1; the new entry becomes head next cycle.
  - count 2: push is impossible because in_ready=0; a pop drops count to 1 and in_ready rises next cycle.
- Full/empty boundaries:
  - Push when full is ignored; it cannot occur legally.
  - Pop when empty is ignored.
  - Read/write pointers are 1 bit and wrap.
- Immediate construction (i = inst; sign bit s = i[31] replicated to XLEN):
  - I: {s.., i[31:20]}
  - S: {s.., i[31:25], i[11:7]}
  - B: {s.., i[7], i[30:25], i[11:8], 0}
  - U: {s.. (XLEN-32 bits), i[31:12], 12'b0}; on XLEN=64 bits [63:32] copy i[31].
  - J: {s.., i[19:12], i[20], i[30:21], 0}
  - Z: see Optional Feature.
- Reserved op (6/7): imm=0, err=1 stored with the entry.
- err is only meaningful when out_valid=1; it is 0 otherwise.
- issued_cnt: +1 on each pop, wraps modulo 2^CNT_W, never saturates.
- Reset (any cycle, including mid-transfer):
  - count=0, pointers=0, out_valid=0, imm=0, err=0, issued_cnt=0.
  - in_ready=1 in the cycle after reset deasserts; it is 0 while rst is high.
  - In-flight entries are discarded.
- When out_valid=1 and out_ready=0, imm and err must stay stable.

Optional Feature:
- Macro: IMM_GEN_ZIMM_EN.
- Defined: op=5 yields imm = zero-extended inst[19:15] (CSR uimm), err=0.
- Undefined: op=5 is treated as reserved, giving imm=0 and err=1; no zimm logic is instantiated.

Test Plan:
- XLEN=32, out_ready=1: push inst=0xFFF00093 with op=I -> next cycle out_valid=1, imm=0xFFFFFFFF, err=0.
- Back-to-back S, B, J pushes:
  - S: 0xFE20AE23 -> imm 0xFFFFFFFC.
  - B: 0xFE000CE3 -> imm 0xFFFFFFF8.
  - J: 0xFFDFF06F -> imm 0xFFFFFFFC.
  - Expected: one result per cycle, in order; issued_cnt=3.
- XLEN=64: push 0x800000B7 with op=U -> imm=0xFFFFFFFF80000000. Push 0x12345037 with op=U -> imm=0x0000000012345000.
- Backpressure:
  - Hold out_ready=0 and push three I-type entries -> in_ready drops after the second accept; imm stays stable.
  - Raise out_ready -> entries drain in order, the third is accepted, issued_cnt=3.
- Error and Z op:
  - op=7 -> imm=0, err=1.
  - op=5, inst[19:15]=5'h1F, with IMM_GEN_ZIMM_EN -> imm=0x1F, err=0.
  - Same stimulus without the macro -> imm=0, err=1.
- Reset mid-operation: with count=2, assert rst for 1 cycle -> out_valid=0, issued_cnt=0, in_ready=1 next cycle, and no stale entry emerges afterwards.
